// File: rtl/c_buffer_drain.sv
// c_buffer_drain: reads 128-bit C-buffer words and streams them out as a row-major 32-bit element stream.
// Optional feature macro C_DRAIN_CLAMP_EN saturates every element to the int8 range [-128, 127].
module c_buffer_drain #(
    parameter int LANES   = 4,
    parameter int ELEM_W  = 32,
    parameter int C_IDX_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [12:0]               M,
    input  logic [8:0]                N,
    output logic                      busy,
    output logic                      done,
    output logic [C_IDX_W-1:0]        C_index,
    output logic                      C_rd_en,
    input  logic [LANES*ELEM_W-1:0]   C_data_out,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ELEM_W-1:0]         out_data,
    output logic                      out_last
);
    localparam int WORD_W = LANES * ELEM_W;
    localparam int LW     = $clog2(LANES);
    localparam int LENW   = LW + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [12:0]        r_m_tot;
    logic [6:0]         r_nb;
    logic [LENW-1:0]    r_last_len;
    logic [12:0]        r_m;
    logic [6:0]         r_b;
    logic [C_IDX_W-1:0] r_ptr;
    logic [C_IDX_W-1:0] r_index;
    logic               r_rd_en, r_rd_last, r_ret_vld, r_ret_last;
    logic [LENW-1:0]    r_rd_len, r_ret_len;
    logic [WORD_W-1:0]  r_slot_data [2];
    logic [LENW-1:0]    r_slot_len  [2];
    logic [1:0]         r_slot_vld, r_slot_last;
    logic               r_head, r_tail;
    logic [LW-1:0]      r_lane;
    logic               r_done;

    logic               w_start_ok, w_start_nop;
    logic               w_xfer, w_at_end, w_free, w_issue, w_last_blk, w_last_rd;
    logic [2:0]         w_credits;
    logic [6:0]         w_nb_in;
    logic [LENW-1:0]    w_last_len_in;
    logic [ELEM_W-1:0]  w_lane_elem;

    // Saturation happens as a word lands in a slot, so the output mux sees final values.
    function automatic logic [WORD_W-1:0] f_fill(input logic [WORD_W-1:0] word);
        logic [WORD_W-1:0] res;
        res = word;
`ifdef C_DRAIN_CLAMP_EN
        for (int j = 0; j < LANES; j++) begin
            logic signed [ELEM_W-1:0] e;
            e = word[WORD_W-1-ELEM_W*j -: ELEM_W];
            res[WORD_W-1-ELEM_W*j -: ELEM_W] = (e > 127)  ? ELEM_W'(127)  :
                                               (e < -128) ? ELEM_W'(-128) : e;
        end
`endif
        return res;
    endfunction

    assign w_start_ok    = (r_state == S_IDLE) && start && (M != '0) && (N != '0);
    assign w_start_nop   = (r_state == S_IDLE) && start && ((M == '0) || (N == '0));
    assign w_nb_in       = 7'((10'(N) + 10'd3) >> LW);
    assign w_last_len_in = LENW'((N - 9'd1) & 9'(LANES - 1)) + LENW'(1);

    assign out_valid  = r_slot_vld[r_head];
    assign w_at_end   = ({1'b0, r_lane} == r_slot_len[r_head] - LENW'(1));
    assign w_xfer     = out_valid && out_ready;
    assign w_free     = w_xfer && w_at_end;
    assign out_last   = out_valid && r_slot_last[r_head] && w_at_end;
    assign out_data   = w_lane_elem;

    // A slot freed this cycle already counts as available to a new read.
    assign w_credits  = 3'(r_slot_vld[0]) + 3'(r_slot_vld[1]) + 3'(r_rd_en) + 3'(r_ret_vld) - 3'(w_free);
    assign w_issue    = (r_state == S_RUN) && (w_credits < 3'd2);
    assign w_last_blk = (r_b == r_nb - 7'd1);
    assign w_last_rd  = w_last_blk && (r_m == r_m_tot - 13'd1);

    assign busy    = (r_state != S_IDLE);
    assign done    = r_done;
    assign C_index = r_index;
    assign C_rd_en = r_rd_en;

    always_comb begin
        // NOTE: each comb output gets a default first so no path can infer a latch.
        w_lane_elem = '0;
        for (int j = 0; j < LANES; j++) begin
            if (r_lane == LW'(j)) w_lane_elem = r_slot_data[r_head][WORD_W-1-ELEM_W*j -: ELEM_W];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (w_start_ok) w_state_nxt = S_RUN;
            S_RUN:   if (w_issue && w_last_rd) w_state_nxt = S_FLUSH;
            S_FLUSH: if (w_free && r_slot_last[r_head]) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_tot     <= '0;
            r_nb        <= '0;
            r_last_len  <= '0;
            r_m         <= '0;
            r_b         <= '0;
            r_ptr       <= '0;
            r_index     <= '0;
            r_rd_en     <= 1'b0;
            r_rd_last   <= 1'b0;
            r_rd_len    <= '0;
            r_ret_vld   <= 1'b0;
            r_ret_last  <= 1'b0;
            r_ret_len   <= '0;
            r_slot_vld  <= '0;
            r_slot_last <= '0;
            r_head      <= 1'b0;
            r_tail      <= 1'b0;
            r_lane      <= '0;
            r_done      <= 1'b0;
            // NOTE: slot storage is reset as well so out_data reads 0 straight out of reset.
            for (int s = 0; s < 2; s++) begin
                r_slot_data[s] <= '0;
                r_slot_len[s]  <= '0;
            end
        end else begin
            r_done     <= w_start_nop || ((r_state == S_FLUSH) && w_free && r_slot_last[r_head]);
            r_rd_en    <= w_issue;
            r_ret_vld  <= r_rd_en;
            r_ret_len  <= r_rd_len;
            r_ret_last <= r_rd_last;

            if (w_start_ok) begin
                r_m_tot    <= M;
                r_nb       <= w_nb_in;
                r_last_len <= w_last_len_in;
                r_m        <= '0;
                r_b        <= '0;
                r_ptr      <= '0;
            end

            // Index walks b*M+m by adding M per block and restarting at the next row.
            if (w_issue) begin
                r_index   <= r_ptr;
                r_rd_len  <= w_last_blk ? r_last_len : LENW'(LANES);
                r_rd_last <= w_last_rd;
                if (w_last_blk) begin
                    r_b   <= '0;
                    r_m   <= r_m + 13'd1;
                    r_ptr <= C_IDX_W'(r_m) + C_IDX_W'(1);
                end else begin
                    r_b   <= r_b + 7'd1;
                    r_ptr <= r_ptr + C_IDX_W'(r_m_tot);
                end
            end

            if (w_xfer) begin
                if (w_at_end) begin
                    r_slot_vld[r_head] <= 1'b0;
                    r_head             <= ~r_head;
                    r_lane             <= '0;
                end else begin
                    r_lane <= r_lane + LW'(1);
                end
            end

            if (r_ret_vld) begin
                r_slot_data[r_tail] <= f_fill(C_data_out);
                r_slot_len[r_tail]  <= r_ret_len;
                r_slot_last[r_tail] <= r_ret_last;
                r_slot_vld[r_tail]  <= 1'b1;
                r_tail              <= ~r_tail;
            end
        end
    end
endmodule

// File: tb/tb_c_buffer_drain.sv
// Self-checking bench for c_buffer_drain: queue-based stream model, C buffer RAM model, directed jobs.
// Honours C_DRAIN_CLAMP_EN when the same macro is defined for the build.
`timescale 1ns/1ps
module tb_c_buffer_drain;
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [12:0]  M;
    logic [8:0]   N;
    logic         busy, done, C_rd_en, out_valid, out_ready, out_last;
    logic [15:0]  C_index;
    logic [127:0] C_data_out = '0;
    logic [31:0]  out_data;

    c_buffer_drain dut (
        .clk(clk), .rst(rst), .start(start), .M(M), .N(N),
        .busy(busy), .done(done), .C_index(C_index), .C_rd_en(C_rd_en),
        .C_data_out(C_data_out), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } elem_t;

    elem_t        exp_q[$];
    int           exp_rd[$];
    int           rd_log[$];
    logic [31:0]  got_q[$];
    logic [127:0] mem [0:255];
    int           n_vec = 0;
    int           n_err = 0;
    int           cyc = 0;
    int           last_hs_cyc = -100;
    int           ready_md = 0;
    bit           track_done = 1'b0;
    logic         prev_stall = 1'b0;
    logic [31:0]  prev_data = '0;
    logic         prev_last = 1'b0;
    elem_t        cmp_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, $signed(act), $signed(exp));
        end
    endtask

    function automatic logic [31:0] mdl_elem(input logic [31:0] v);
`ifdef C_DRAIN_CLAMP_EN
        int s;
        s = v;
        if (s > 127)  return 32'd127;
        if (s < -128) return 32'hFFFF_FF80;
`endif
        return v;
    endfunction

    // C buffer RAM: one-cycle read latency.
    always @(posedge clk) begin
        if (C_rd_en) begin
            C_data_out <= mem[C_index[7:0]];
            rd_log.push_back(int'(C_index));
        end
    end

    // Consumer: ready always high, or the repeating 1,0,0,1 pattern.
    initial begin
        int rc;
        rc = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rc++;
            out_ready = (ready_md == 0) || (rc % 4 == 0) || (rc % 4 == 3);
        end
    end

    // Compare process: stall stability, element order/value/last, done timing.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", out_data, prev_data);
                check("hold_last", 32'(out_last), 32'(prev_last));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL extra_elem: got %0d, want no element", $signed(out_data));
                end else begin
                    cmp_e = exp_q.pop_front();
                    check("elem_data", out_data, cmp_e.d);
                    check("elem_last", 32'(out_last), 32'(cmp_e.l));
                end
                got_q.push_back(out_data);
                if (out_last) last_hs_cyc = cyc;
            end
            if (done && track_done) check("done_timing", 32'(cyc - last_hs_cyc), 32'd1);
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    // Element C[m][n] = m*N+n, so the row-major stream reads 0,1,2,...; padding lanes hold junk.
    task automatic fill_pattern(input int mm, input int nn);
        int nb;
        int n;
        nb = (nn + 3) / 4;
        for (int b = 0; b < nb; b++)
            for (int m = 0; m < mm; m++)
                for (int j = 0; j < 4; j++) begin
                    n = 4 * b + j;
                    mem[b*mm+m][127-32*j -: 32] = (n < nn) ? 32'(m * nn + n) : (32'hBAD0_0000 | 32'(b * 64 + m * 4 + j));
                end
    endtask

    task automatic derive(input int mm, input int nn);
        int           nb;
        int           len;
        logic [127:0] w;
        elem_t        e;
        nb = (nn + 3) / 4;
        exp_q.delete();
        exp_rd.delete();
        got_q.delete();
        rd_log.delete();
        for (int m = 0; m < mm; m++)
            for (int b = 0; b < nb; b++) begin
                exp_rd.push_back(b * mm + m);
                w   = mem[b*mm+m];
                len = (nn - 4 * b >= 4) ? 4 : nn - 4 * b;
                for (int j = 0; j < len; j++) begin
                    e.d = mdl_elem(w[127-32*j -: 32]);
                    e.l = (m == mm - 1) && (4 * b + j == nn - 1);
                    exp_q.push_back(e);
                end
            end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_rd_en"}, 32'(C_rd_en), 32'd0);
        check({tag, "_index"}, 32'(C_index), 32'd0);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_data"}, out_data, 32'd0);
        check({tag, "_last"}, 32'(out_last), 32'd0);
    endtask

    task automatic run_job(input int mm, input int nn, input int mode, input int abort_at, input int restart_at);
        int lat;
        int budget;
        bit fin;
        ready_md   = mode;
        lat        = -1;
        fin        = 1'b0;
        budget     = 4 * mm * nn + 40;
        track_done = (abort_at == 0);
        @(posedge clk);
        #1;
        M     = 13'(mm);
        N     = 9'(nn);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= budget && !fin; k++) begin
            @(posedge clk);
            #1;
            if (k == restart_at) begin
                M     = 13'd7;
                N     = 9'd3;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (lat < 0 && out_valid) lat = k;
            if (abort_at > 0 && got_q.size() >= abort_at) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                check_reset_outputs("midrst");
                rst = 1'b0;
                exp_q.delete();
                return;
            end
            if (done) fin = 1'b1;
        end
        if (!fin) begin
            n_vec++;
            n_err++;
            $display("FAIL done_timeout: got no done, want done within %0d cycles", budget);
        end
        check("first_valid_latency", 32'(lat), 32'd3);
        check("elems_left", 32'(exp_q.size()), 32'd0);
        check("busy_after_done", 32'(busy), 32'd0);
        check("read_count", 32'(rd_log.size()), 32'(exp_rd.size()));
        for (int i = 0; i < exp_rd.size() && i < rd_log.size(); i++)
            check("read_index", 32'(rd_log[i]), 32'(exp_rd[i]));
    endtask

    task automatic run_zero(input int mm, input int nn);
        track_done = 1'b0;
        rd_log.delete();
        @(posedge clk);
        #1;
        M     = 13'(mm);
        N     = 9'(nn);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("zero_done_pulse", 32'(done), 32'd1);
        check("zero_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check("zero_done_clear", 32'(done), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("zero_no_reads", 32'(rd_log.size()), 32'd0);
    endtask

    task automatic check_ramp(input string tag, input int count);
        check({tag, "_count"}, 32'(got_q.size()), 32'(count));
        for (int i = 0; i < count && i < got_q.size(); i++)
            check({tag, "_value"}, got_q[i], 32'(i));
    endtask

    initial begin
        int          t2_rd[6];
        logic [31:0] t5_exp[4];
        t2_rd = '{0, 3, 1, 4, 2, 5};
`ifdef C_DRAIN_CLAMP_EN
        t5_exp = '{32'd127, 32'hFFFF_FF80, 32'd127, 32'hFFFF_FF80};
`else
        t5_exp = '{32'd300, 32'hFFFF_FC18, 32'd127, 32'hFFFF_FF80};
`endif
        rst   = 1'b1;
        start = 1'b0;
        M     = '0;
        N     = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // 4x4, full rate: stream 0..15, last on the 16th.
        fill_pattern(4, 4);
        derive(4, 4);
        run_job(4, 4, 0, 0, 0);
        check_ramp("t1", 16);

        // 3x6: two blocks per row, padding lanes skipped.
        fill_pattern(3, 6);
        derive(3, 6);
        run_job(3, 6, 0, 0, 0);
        for (int i = 0; i < 6 && i < rd_log.size(); i++)
            check("t2_read_order", 32'(rd_log[i]), 32'(t2_rd[i]));
        check_ramp("t2", 18);

        // 2x4 with a stalling consumer.
        fill_pattern(2, 4);
        derive(2, 4);
        run_job(2, 4, 1, 0, 0);
        check_ramp("t3", 8);

        // 4x16 aborted by reset at element 5, then rerun in full.
        fill_pattern(4, 16);
        derive(4, 16);
        run_job(4, 16, 0, 5, 0);
        derive(4, 16);
        run_job(4, 16, 0, 0, 0);
        check_ramp("t4", 64);

        // Saturation corner values in one word.
        mem[0] = {32'd300, 32'hFFFF_FC18, 32'd127, 32'hFFFF_FF80};
        derive(1, 4);
        run_job(1, 4, 0, 0, 0);
        for (int i = 0; i < 4 && i < got_q.size(); i++)
            check("t5_clamp", got_q[i], t5_exp[i]);

        // Start re-pulsed mid-run is ignored; M=0 and N=0 starts are no-ops.
        fill_pattern(3, 6);
        derive(3, 6);
        run_job(3, 6, 1, 0, 5);
        check_ramp("t6", 18);
        run_zero(0, 5);
        run_zero(3, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
